// File: rtl/eq_pkg.sv
// Shared definitions for the pot scanner: slot order, slot-to-channel map,
// register reset values and the smoothing helper.
package eq_pkg;

  typedef enum logic [2:0] {
    SLOT_LP  = 3'd0,
    SLOT_B1  = 3'd1,
    SLOT_B2  = 3'd2,
    SLOT_B3  = 3'd3,
    SLOT_HP  = 3'd4,
    SLOT_VOL = 3'd5
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int NUM_SLOTS = 6;

  localparam logic [11:0] POT_RST_VAL = 12'h000;
  localparam logic [11:0] VOL_RST_VAL = 12'h800;

  function automatic logic [2:0] slot_chnnl(input slot_e s);
    case (s)
      SLOT_LP:  return 3'd1;
      SLOT_B1:  return 3'd0;
      SLOT_B2:  return 3'd4;
      SLOT_B3:  return 3'd2;
      SLOT_HP:  return 3'd3;
      SLOT_VOL: return 3'd7;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic slot_e slot_next(input slot_e s);
    return (s == SLOT_VOL) ? SLOT_LP : slot_e'(s + 3'd1);
  endfunction

  // VOLUME powers up at mid-scale so the output is not silent or at full volume.
  function automatic logic [11:0] slot_rst_val(input slot_e s);
    return (s == SLOT_VOL) ? VOL_RST_VAL : POT_RST_VAL;
  endfunction

  // (3*old + new) >> 2; 14 bits hold the worst case 4*4095.
  function automatic logic [11:0] smooth(input logic [11:0] old_val, input logic [11:0] new_val);
    logic [13:0] acc;
    acc = {2'b00, old_val} + {1'b0, old_val, 1'b0} + {2'b00, new_val};
    return acc[13:2];
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Down-counter shared by the conversion timeout and the inter-conversion gap.
// load wins over count; done is high while the count is zero.
module scan_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pot_scan_sched.sv
// Round-robin scheduler reading six pots through an A2D converter.
// Optional build macro POT_SMOOTH_EN: low-pass each new sample into its register.
module pot_scan_sched
  import eq_pkg::*;
#(
  parameter int GAP_CYCLES = 1024,
  parameter int TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] VOLUME,
  output logic        scan_done,
  output logic        tmo_err,
  output logic [1:0]  state_dbg
);

  localparam int MAX_CYC = (GAP_CYCLES > TMO_CYCLES) ? GAP_CYCLES : TMO_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYCLES - 1);

  // Handshake: strt_cnv is a one-cycle request on chnnl; the converter answers
  // with a one-cycle cnv_cmplt carrying res. Only a cnv_cmplt seen in WAIT counts.

  state_e      state;
  slot_e       slot;
  logic [11:0] pot_q [NUM_SLOTS];

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_count;
  logic          tmr_done;

  function automatic logic [11:0] pot_update(input logic [11:0] old_val, input logic [11:0] new_val);
`ifdef POT_SMOOTH_EN
    return smooth(old_val, new_val);
`else
    return (old_val & 12'h000) | new_val;
`endif
  endfunction

  // Timer is loaded with N-1 so WAIT/GAP last exactly N cycles including the done cycle.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_val   = TMO_LOAD;
    tmr_count = 1'b0;
    case (state)
      ST_START: begin
        tmr_load = 1'b1;
        tmr_val  = TMO_LOAD;
      end
      ST_WAIT: begin
        if (cnv_cmplt || tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else begin
          tmr_count = 1'b1;
        end
      end
      ST_GAP:  tmr_count = 1'b1;
      default: ;
    endcase
  end

  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      slot      <= SLOT_LP;
      strt_cnv  <= 1'b0;
      scan_done <= 1'b0;
      tmo_err   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pot_q[i] <= slot_rst_val(slot_e'(i[2:0]));
      end
    end else begin
      strt_cnv  <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scan_en) begin
            state    <= ST_START;
            strt_cnv <= 1'b1;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          // Completion beats a same-cycle timeout; a timeout keeps the old value.
          if (cnv_cmplt || tmr_done) begin
            if (cnv_cmplt) begin
              pot_q[slot] <= pot_update(pot_q[slot], res);
            end else begin
              tmo_err <= 1'b1;
            end
            slot      <= slot_next(slot);
            scan_done <= (slot == SLOT_VOL);
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_done) begin
            if (scan_en) begin
              state    <= ST_START;
              strt_cnv <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign chnnl     = slot_chnnl(slot);
  assign state_dbg = state;

  assign POT_LP = pot_q[SLOT_LP];
  assign POT_B1 = pot_q[SLOT_B1];
  assign POT_B2 = pot_q[SLOT_B2];
  assign POT_B3 = pot_q[SLOT_B3];
  assign POT_HP = pot_q[SLOT_HP];
  assign VOLUME = pot_q[SLOT_VOL];

endmodule

// File: tb/tb_pot_scan_sched.sv
// Self-checking bench for pot_scan_sched: scan order, timeout, scan_en drop,
// mid-conversion reset and stray completions.
module tb_pot_scan_sched;

  localparam int GAP = 1024;
  localparam int TMO = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;
  logic        scan_done;
  logic        tmo_err;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  pot_scan_sched #(.GAP_CYCLES(GAP), .TMO_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .POT_LP    (POT_LP),
    .POT_B1    (POT_B1),
    .POT_B2    (POT_B2),
    .POT_B3    (POT_B3),
    .POT_HP    (POT_HP),
    .VOLUME    (VOLUME),
    .scan_done (scan_done),
    .tmo_err   (tmo_err),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic [11:0] res;
    int          lat;
    logic [2:0]  exp_chn;
  } vec_t;

  vec_t        vecs [7];
  logic [11:0] exp_q [$];
  logic [11:0] model_pot [6];
  logic [2:0]  chn_tbl [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
  int          model_slot;
  int          n_chk = 0;
  int          n_fail = 0;
  int          strt_cnt = 0;
  int          done_cnt = 0;
  int          n;
  int          strt_before;

  always @(negedge clk) begin
    if (strt_cnv) strt_cnt++;
    if (scan_done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_update(input logic [11:0] old_val, input logic [11:0] new_val);
`ifdef POT_SMOOTH_EN
    int acc;
    acc = 3 * int'(old_val) + int'(new_val);
    return 12'(acc / 4);
`else
    return new_val;
`endif
  endfunction

  function automatic logic [11:0] pot_of(input int s);
    case (s)
      0:       return POT_LP;
      1:       return POT_B1;
      2:       return POT_B2;
      3:       return POT_B3;
      4:       return POT_HP;
      default: return VOLUME;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) model_pot[i] = (i == 5) ? 12'h800 : 12'h000;
    model_slot = 0;
  endtask

  task automatic check_all_pots(input string name);
    for (int i = 0; i < 6; i++) check(name, 32'(pot_of(i)), 32'(model_pot[i]));
  endtask

  task automatic wait_strt(input int limit, output int cnt);
    cnt = 0;
    while (!strt_cnv && cnt < limit) begin
      tick();
      cnt++;
    end
    check("strt_cnv_seen", 32'(strt_cnv), 32'd1);
    check("chnnl_at_start", 32'(chnnl), 32'(chn_tbl[model_slot]));
  endtask

  task automatic complete(input logic [11:0] val);
    int          s;
    logic [11:0] e;
    s = model_slot;
    e = exp_update(model_pot[s], val);
    exp_q.push_back(e);
    cnv_cmplt = 1'b1;
    res       = val;
    tick();
    cnv_cmplt = 1'b0;
    model_pot[s] = e;
    model_slot   = (s + 1) % 6;
    check("pot_write", 32'(pot_of(s)), 32'(exp_q.pop_front()));
    check("scan_done_pulse", 32'(scan_done), (s == 5) ? 32'd1 : 32'd0);
    check("state_gap", 32'(state_dbg), 32'd3);
  endtask

  initial begin
    rst_n     = 1'b0;
    scan_en   = 1'b0;
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    vecs = '{
      '{12'hABC, 3, 3'd1},
      '{12'h123, 5, 3'd0},
      '{12'h456, 1, 3'd4},
      '{12'h789, 8, 3'd2},
      '{12'hFFF, 2, 3'd3},
      '{12'h3C5, 4, 3'd7},
      '{12'h001, 6, 3'd1}
    };
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_strt_cnv", 32'(strt_cnv), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_tmo_err", 32'(tmo_err), 32'd0);
    check("rst_chnnl", 32'(chnnl), 32'd1);
    check_all_pots("rst_pot");
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_hold", 32'(state_dbg), 32'd0);
    check("idle_no_strt", 32'(strt_cnt), 32'd0);

    // Stray completion while idle
    cnv_cmplt = 1'b1;
    res       = 12'h555;
    tick();
    cnv_cmplt = 1'b0;
    check_all_pots("idle_stray_pot");
    check("idle_stray_state", 32'(state_dbg), 32'd0);

    // Full scan plus wrap to LP
    scan_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_strt(GAP + 20, n);
      check("seq_chnnl", 32'(chnnl), 32'(vecs[i].exp_chn));
      if (i == 0) check("idle_to_start", n, 32'd1);
      else        check("gap_len", n, GAP);
      tick();
      check("strt_one_cycle", 32'(strt_cnv), 32'd0);
      check("state_wait", 32'(state_dbg), 32'd2);
      repeat (vecs[i].lat - 1) tick();
      complete(vecs[i].res);
    end
    check("scan_done_count", done_cnt, 32'd1);

    // scan_en dropped mid-WAIT on B1
    wait_strt(GAP + 20, n);
    tick();
    tick();
    scan_en = 1'b0;
    tick();
    complete(12'h2D2);
    strt_before = strt_cnt;
    repeat (GAP + 10) tick();
    check("idle_after_drop", 32'(state_dbg), 32'd0);
    check("no_restart", strt_cnt, strt_before);
    scan_en = 1'b1;
    wait_strt(20, n);
    check("resume_chnnl", 32'(chnnl), 32'd4);

    // Timeout on B2
    tick();
    check("tmo_early", 32'(tmo_err), 32'd0);
    repeat (TMO - 1) tick();
    check("tmo_not_yet", 32'(tmo_err), 32'd0);
    check("tmo_still_wait", 32'(state_dbg), 32'd2);
    tick();
    model_slot = 3;
    check("tmo_set", 32'(tmo_err), 32'd1);
    check("tmo_b2_kept", 32'(POT_B2), 32'(model_pot[2]));
    check("tmo_next_chnnl", 32'(chnnl), 32'd2);
    check("tmo_state_gap", 32'(state_dbg), 32'd3);

    // Stray completion inside GAP after B3
    wait_strt(GAP + 20, n);
    check("gap_after_tmo", n, GAP);
    tick();
    complete(12'hA5A);
    repeat (100) tick();
    cnv_cmplt = 1'b1;
    res       = 12'hFFF;
    tick();
    cnv_cmplt = 1'b0;
    check_all_pots("gap_stray_pot");
    check("gap_stray_state", 32'(state_dbg), 32'd3);
    wait_strt(GAP + 20, n);
    check("gap_with_stray", 101 + n, GAP);
    check("tmo_sticky", 32'(tmo_err), 32'd1);

    // Reset pulsed during WAIT on HP
    tick();
    tick();
    scan_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    model_reset();
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_volume", 32'(VOLUME), 32'h800);
    check("mid_rst_tmo", 32'(tmo_err), 32'd0);
    check("mid_rst_chnnl", 32'(chnnl), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    cnv_cmplt = 1'b1;
    res       = 12'h123;
    tick();
    cnv_cmplt = 1'b0;
    check_all_pots("late_cmplt_pot");
    check("late_cmplt_state", 32'(state_dbg), 32'd0);

    // Scanning restarts at LP after reset
    scan_en = 1'b1;
    wait_strt(20, n);
    tick();
    complete(12'h0F0);
    check("final_done_count", done_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
